// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
//
// Clocked, parametrised ALU. Arithmetic/logic/compare ops finish in one cycle.
// Variable shifts, rotates and masks walk one bit position per clock through a
// single-bit shifter. Results and flags are registered and qualified by Done.
//
// Build option:
//   ALU_ROTATE_EN  - when defined, ROL (9) and ROR (10) are implemented; when
//                    undefined they decode as illegal and the rotate path is
//                    not built.
//
// Parameters:
//   W    - data width (>= 4)
//   Ops  - opcode width (>= 4)
//
// Ports:
//   Clk_i       in   clock, all state on rising edge
//   Reset_n_i   in   asynchronous active-low reset
//   Start_i     in   request, sampled only while Busy_o = 0
//   InputA_i    in   operand A
//   InputB_i    in   operand B / unsigned shift count
//   OP_i        in   opcode
//   SC_in_i     in   carry-in for ADD
//   Busy_o      out  multi-cycle op in progress
//   Done_o      out  one-cycle completion pulse
//   Out_o       out  result, held until next completion
//   Zero_o, Parity_o, Odd_o, Carry_o, Illegal_o  out  registered status flags
// -----------------------------------------------------------------------------
module iterative_alu #(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk_i,
    input  logic           Reset_n_i,
    input  logic           Start_i,
    input  logic [W-1:0]   InputA_i,
    input  logic [W-1:0]   InputB_i,
    input  logic [Ops-1:0] OP_i,
    input  logic           SC_in_i,
    output logic           Busy_o,
    output logic           Done_o,
    output logic [W-1:0]   Out_o,
    output logic           Zero_o,
    output logic           Parity_o,
    output logic           Odd_o,
    output logic           Carry_o,
    output logic           Illegal_o
);

    localparam int CW = $clog2(W + 1);

    localparam logic [Ops-1:0] OP_ADD = Ops'(0);
    localparam logic [Ops-1:0] OP_LSL = Ops'(1);
    localparam logic [Ops-1:0] OP_LSR = Ops'(2);
    localparam logic [Ops-1:0] OP_XOR = Ops'(3);
    localparam logic [Ops-1:0] OP_SNE = Ops'(4);
    localparam logic [Ops-1:0] OP_SEQ = Ops'(5);
    localparam logic [Ops-1:0] OP_MSK = Ops'(6);
    localparam logic [Ops-1:0] OP_SUB = Ops'(7);
    localparam logic [Ops-1:0] OP_ASR = Ops'(8);
    localparam logic [Ops-1:0] OP_ROL = Ops'(9);
    localparam logic [Ops-1:0] OP_ROR = Ops'(10);

    localparam logic [W-1:0]  W_AS_DATA = W'(W);
    localparam logic [CW-1:0] W_AS_CNT  = CW'(W);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e         state_q, state_d;
    logic [Ops-1:0] op_q;
    logic [W-1:0]   work_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   out_q;
    logic           zero_q, parity_q, odd_q, carry_q, illegal_q, done_q;

    // Decode of the incoming request
    logic           is_legal;
    logic           is_shift_op;
`ifdef ALU_ROTATE_EN
    logic           is_rot;
`endif
    logic [CW-1:0]  n_cnt;

    // One-cycle result path
    logic [W:0]     sum_ext;
    logic [W-1:0]   one_res;
    logic           one_carry;
    logic           one_illegal;

    // Single-bit shifter path
    logic [W-1:0]   step_res;
    logic           step_bit;

    // Control strobes
    logic           accept;
    logic           accept_shift;
    logic           finish_shift;
    logic           complete;
    logic [W-1:0]   fin_res;
    logic           fin_carry;
    logic           fin_illegal;

    // ---------------------------------------------------------------- decode
    always_comb begin
        is_legal    = 1'b1;
        is_shift_op = 1'b0;
`ifdef ALU_ROTATE_EN
        is_rot      = 1'b0;
`endif
        case (OP_i)
            OP_ADD, OP_XOR, OP_SNE, OP_SEQ, OP_SUB: is_legal = 1'b1;
            OP_LSL, OP_LSR, OP_MSK, OP_ASR:         is_shift_op = 1'b1;
            OP_ROL, OP_ROR: begin
`ifdef ALU_ROTATE_EN
                is_shift_op = 1'b1;
                is_rot      = 1'b1;
`else
                is_legal    = 1'b0;
`endif
            end
            default: is_legal = 1'b0;
        endcase
    end

    // Shift count: linear shifts saturate at W, rotates wrap modulo W.
    always_comb begin
        n_cnt = (InputB_i > W_AS_DATA) ? W_AS_CNT : CW'(InputB_i);
`ifdef ALU_ROTATE_EN
        if (is_rot) begin
            n_cnt = CW'(InputB_i % W_AS_DATA);
        end
`endif
    end

    // ------------------------------------------------------ one-cycle result
    assign sum_ext = {1'b0, InputA_i} + {1'b0, InputB_i} + {{W{1'b0}}, SC_in_i};

    always_comb begin
        one_res     = '0;
        one_carry   = 1'b0;
        one_illegal = 1'b0;
        if (!is_legal) begin
            one_illegal = 1'b1;
        end else if (is_shift_op) begin
            // Only reached with a zero count: pass-through (MSK gives 1).
            one_res = (OP_i == OP_MSK) ? W'(1) : InputA_i;
        end else begin
            case (OP_i)
                OP_ADD: begin
                    one_res   = sum_ext[W-1:0];
                    one_carry = sum_ext[W];
                end
                OP_XOR: one_res = InputA_i ^ InputB_i;
                OP_SNE: one_res = (InputA_i != InputB_i) ? W'(1) : '0;
                OP_SEQ: one_res = (InputA_i == InputB_i) ? W'(1) : '0;
                OP_SUB: begin
                    one_res   = InputA_i - InputB_i;
                    one_carry = (InputA_i >= InputB_i);
                end
                default: one_res = '0;
            endcase
        end
    end

    // ------------------------------------------------------ single-bit shifter
    always_comb begin
        step_res = work_q;
        step_bit = 1'b0;
        case (op_q)
            OP_LSL, OP_MSK: begin
                step_res = {work_q[W-2:0], 1'b0};
                step_bit = work_q[W-1];
            end
            OP_LSR: begin
                step_res = {1'b0, work_q[W-1:1]};
                step_bit = work_q[0];
            end
            OP_ASR: begin
                step_res = {work_q[W-1], work_q[W-1:1]};
                step_bit = work_q[0];
            end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin
                step_res = {work_q[W-2:0], work_q[W-1]};
                step_bit = work_q[W-1];
            end
            OP_ROR: begin
                step_res = {work_q[0], work_q[W-1:1]};
                step_bit = work_q[0];
            end
`endif
            default: begin
                step_res = work_q;
                step_bit = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------ FSM: state
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start_i && is_shift_op && (n_cnt != '0)) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_ONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- FSM: outputs
    always_comb begin
        Busy_o       = (state_q == S_SHIFT);
        accept       = (state_q == S_IDLE) && Start_i;
        accept_shift = accept && is_shift_op && (n_cnt != '0);
        // The step taken with the counter at 1 is the last one, so its result
        // is written straight into Out.
        finish_shift = (state_q == S_SHIFT) && (cnt_q == CNT_ONE);
        complete     = (accept && !accept_shift) || finish_shift;
        fin_res      = finish_shift ? step_res : one_res;
        fin_carry    = finish_shift ? step_bit : one_carry;
        fin_illegal  = finish_shift ? 1'b0     : one_illegal;
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            op_q      <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            zero_q    <= 1'b1;
            parity_q  <= 1'b0;
            odd_q     <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= complete;
            if (complete) begin
                out_q     <= fin_res;
                zero_q    <= ~|fin_res;
                parity_q  <= ^fin_res;
                odd_q     <= fin_res[0];
                carry_q   <= fin_carry;
                illegal_q <= fin_illegal;
            end
            if (accept_shift) begin
                op_q   <= OP_i;
                work_q <= (OP_i == OP_MSK) ? W'(1) : InputA_i;
                cnt_q  <= n_cnt;
            end else if (state_q == S_SHIFT) begin
                work_q <= step_res;
                cnt_q  <= cnt_q - CNT_ONE;
            end
        end
    end

    assign Done_o    = done_q;
    assign Out_o     = out_q;
    assign Zero_o    = zero_q;
    assign Parity_o  = parity_q;
    assign Odd_o     = odd_q;
    assign Carry_o   = carry_q;
    assign Illegal_o = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// -----------------------------------------------------------------------------
// tb_iterative_alu
//
// Directed bench for iterative_alu (W=8, Ops=4). Each scenario task drives its
// own stimulus and compares against hand-computed values. Flags are compared
// as the vector {Zero, Parity, Odd, Carry, Illegal}. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_iterative_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       sc;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       zero, parity, odd, carry, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iterative_alu #(.W(8), .Ops(4)) dut (
        .Clk_i     (clk),
        .Reset_n_i (rst_n),
        .Start_i   (start),
        .InputA_i  (a),
        .InputB_i  (b),
        .OP_i      (op),
        .SC_in_i   (sc),
        .Busy_o    (busy),
        .Done_o    (done),
        .Out_o     (out),
        .Zero_o    (zero),
        .Parity_o  (parity),
        .Odd_o     (odd),
        .Carry_o   (carry),
        .Illegal_o (illegal)
    );

    // Issue one request and wait (bounded) for Done. lat counts cycles from
    // the accept edge; busy_cnt counts Busy cycles before Done. Operands are
    // scrambled right after accept to show they are latched.
    task automatic run_op(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib,
                          input logic isc, output int lat, output int busy_cnt);
        @(negedge clk);
        op = o; a = ia; b = ib; sc = isc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = 8'h00; sc = ~isc;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int dones = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0; sc = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=0", dones); end
        total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({zero, parity, odd, carry, illegal} !== 5'b10000) begin
            bad++; $display("FAIL reset_flags got=%b exp=10000", {zero, parity, odd, carry, illegal});
        end
        $display("reset: out=%h busy=%b flags=%b", out, busy, {zero, parity, odd, carry, illegal});
    endtask

    task automatic test_add_sub();
        int lat, bc;
        run_op(4'd0, 8'hFF, 8'h01, 1'b1, lat, bc);
        $display("ADD FF+01+1: out=%h lat=%0d flags=%b", out, lat, {zero, parity, odd, carry, illegal});
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
        total++; if (out !== 8'h01) begin bad++; $display("FAIL add_out got=%h exp=01", out); end
        total++; if ({zero, parity, odd, carry, illegal} !== 5'b01110) begin
            bad++; $display("FAIL add_flags got=%b exp=01110", {zero, parity, odd, carry, illegal});
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done); end

        run_op(4'd7, 8'h03, 8'h05, 1'b1, lat, bc);
        $display("SUB 03-05: out=%h lat=%0d flags=%b", out, lat, {zero, parity, odd, carry, illegal});
        total++; if (out !== 8'hFE) begin bad++; $display("FAIL sub_out got=%h exp=FE", out); end
        total++; if ({zero, parity, odd, carry, illegal} !== 5'b01000) begin
            bad++; $display("FAIL sub_flags got=%b exp=01000", {zero, parity, odd, carry, illegal});
        end

        run_op(4'd7, 8'h05, 8'h05, 1'b0, lat, bc);
        $display("SUB 05-05: out=%h flags=%b", out, {zero, parity, odd, carry, illegal});
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'h00, 5'b10010}) begin
            bad++; $display("FAIL sub_equal got=%h/%b exp=00/10010", out, {zero, parity, odd, carry, illegal});
        end
    endtask

    task automatic test_logic();
        int lat, bc;
        run_op(4'd3, 8'hA5, 8'h0F, 1'b0, lat, bc);
        $display("XOR A5^0F: out=%h flags=%b", out, {zero, parity, odd, carry, illegal});
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'hAA, 5'b00000}) begin
            bad++; $display("FAIL xor got=%h/%b exp=AA/00000", out, {zero, parity, odd, carry, illegal});
        end
        run_op(4'd4, 8'h05, 8'h05, 1'b0, lat, bc);
        $display("SNE 05,05: out=%h", out);
        total++; if ({out, zero} !== {8'h00, 1'b1}) begin
            bad++; $display("FAIL sne got=%h/%b exp=00/1", out, zero);
        end
        run_op(4'd5, 8'h05, 8'h05, 1'b0, lat, bc);
        $display("SEQ 05,05: out=%h flags=%b", out, {zero, parity, odd, carry, illegal});
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'h01, 5'b01100}) begin
            bad++; $display("FAIL seq got=%h/%b exp=01/01100", out, {zero, parity, odd, carry, illegal});
        end
    endtask

    task automatic test_shift();
        int lat, bc;
        run_op(4'd1, 8'h81, 8'd3, 1'b0, lat, bc);
        $display("LSL 81<<3: out=%h lat=%0d busy=%0d flags=%b", out, lat, bc, {zero, parity, odd, carry, illegal});
        total++; if (lat !== 4) begin bad++; $display("FAIL lsl3_latency got=%0d exp=4", lat); end
        total++; if (bc !== 3) begin bad++; $display("FAIL lsl3_busy got=%0d exp=3", bc); end
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'h08, 5'b01000}) begin
            bad++; $display("FAIL lsl3 got=%h/%b exp=08/01000", out, {zero, parity, odd, carry, illegal});
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lsl3_busy_at_done got=%b exp=0", busy); end

        run_op(4'd1, 8'h81, 8'd200, 1'b0, lat, bc);
        $display("LSL 81<<200: out=%h lat=%0d flags=%b", out, lat, {zero, parity, odd, carry, illegal});
        total++; if (lat !== 9) begin bad++; $display("FAIL lsl_sat_latency got=%0d exp=9", lat); end
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'h00, 5'b10010}) begin
            bad++; $display("FAIL lsl_sat got=%h/%b exp=00/10010", out, {zero, parity, odd, carry, illegal});
        end

        run_op(4'd2, 8'h5A, 8'd0, 1'b0, lat, bc);
        $display("LSR 5A>>0: out=%h lat=%0d", out, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL lsr0_latency got=%0d exp=1", lat); end
        total++; if ({out, carry} !== {8'h5A, 1'b0}) begin
            bad++; $display("FAIL lsr0 got=%h/%b exp=5A/0", out, carry);
        end

        run_op(4'd8, 8'h90, 8'd9, 1'b0, lat, bc);
        $display("ASR 90>>9: out=%h lat=%0d flags=%b", out, lat, {zero, parity, odd, carry, illegal});
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'hFF, 5'b00110} || lat !== 9) begin
            bad++; $display("FAIL asr_sat got=%h/%b lat=%0d exp=FF/00110 lat=9",
                            out, {zero, parity, odd, carry, illegal}, lat);
        end

        run_op(4'd2, 8'hC1, 8'd2, 1'b0, lat, bc);
        $display("LSR C1>>2: out=%h flags=%b", out, {zero, parity, odd, carry, illegal});
        total++; if ({out, carry} !== {8'h30, 1'b0} || lat !== 3) begin
            bad++; $display("FAIL lsr2 got=%h/%b lat=%0d exp=30/0 lat=3", out, carry, lat);
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int overlap = 0;
        @(negedge clk);
        op = 4'd8; a = 8'h90; b = 8'd2; sc = 1'b0; start = 1'b1;
        @(negedge clk);
        // Busy now; a competing ADD must be ignored.
        op = 4'd0; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            if (done && busy) overlap++;
            @(negedge clk);
        end
        $display("ASR 90>>2 with stray starts: out=%h dones=%0d", out, dones);
        total++; if (dones !== 1) begin bad++; $display("FAIL asr_single_done got=%0d exp=1", dones); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL asr_done_busy got=%0d exp=0", overlap); end
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'hE4, 5'b00000}) begin
            bad++; $display("FAIL asr2 got=%h/%b exp=E4/00000", out, {zero, parity, odd, carry, illegal});
        end
    endtask

    task automatic test_mask_reset();
        int lat, bc;
        int dones = 0;
        run_op(4'd6, 8'h00, 8'd6, 1'b0, lat, bc);
        $display("MSK 6: out=%h lat=%0d", out, lat);
        total++; if ({out, carry, lat} !== {8'h40, 1'b0, 32'd7}) begin
            bad++; $display("FAIL msk6 got=%h/%b lat=%0d exp=40/0 lat=7", out, carry, lat);
        end

        @(negedge clk);
        op = 4'd6; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({out, zero, busy, done} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL msk_reset_now got=%h/%b/%b/%b exp=00/1/0/0", out, zero, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        $display("MSK 7 reset mid-shift: out=%h dones=%0d", out, dones);
        total++; if (dones !== 0 || out !== 8'h00) begin
            bad++; $display("FAIL msk_reset_nodone got=%0d/%h exp=0/00", dones, out);
        end

        run_op(4'd3, 8'hF0, 8'h3C, 1'b0, lat, bc);
        $display("XOR after reset: out=%h lat=%0d", out, lat);
        total++; if ({out, lat} !== {8'hCC, 32'd1}) begin
            bad++; $display("FAIL post_reset_xor got=%h lat=%0d exp=CC lat=1", out, lat);
        end
    endtask

    task automatic test_rotate_illegal();
        int lat, bc;
        run_op(4'd10, 8'h01, 8'd9, 1'b0, lat, bc);
        $display("ROR 01 by 9: out=%h lat=%0d flags=%b", out, lat, {zero, parity, odd, carry, illegal});
`ifdef ALU_ROTATE_EN
        total++; if ({out, zero, parity, odd, carry, illegal, lat} !== {8'h80, 5'b01010, 32'd2}) begin
            bad++; $display("FAIL ror got=%h/%b lat=%0d exp=80/01010 lat=2",
                            out, {zero, parity, odd, carry, illegal}, lat);
        end
`else
        total++; if ({out, zero, parity, odd, carry, illegal, lat} !== {8'h00, 5'b10001, 32'd1}) begin
            bad++; $display("FAIL ror_illegal got=%h/%b lat=%0d exp=00/10001 lat=1",
                            out, {zero, parity, odd, carry, illegal}, lat);
        end
`endif
        run_op(4'd9, 8'h81, 8'd1, 1'b0, lat, bc);
        $display("ROL 81 by 1: out=%h flags=%b", out, {zero, parity, odd, carry, illegal});
`ifdef ALU_ROTATE_EN
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'h03, 5'b00110}) begin
            bad++; $display("FAIL rol got=%h/%b exp=03/00110", out, {zero, parity, odd, carry, illegal});
        end
`else
        total++; if ({out, zero, parity, odd, carry, illegal} !== {8'h00, 5'b10001}) begin
            bad++; $display("FAIL rol_illegal got=%h/%b exp=00/10001", out, {zero, parity, odd, carry, illegal});
        end
`endif
        run_op(4'd15, 8'h12, 8'h34, 1'b1, lat, bc);
        $display("OP15: out=%h lat=%0d flags=%b", out, lat, {zero, parity, odd, carry, illegal});
        total++; if ({out, zero, parity, odd, carry, illegal, lat} !== {8'h00, 5'b10001, 32'd1}) begin
            bad++; $display("FAIL op15 got=%h/%b lat=%0d exp=00/10001 lat=1",
                            out, {zero, parity, odd, carry, illegal}, lat);
        end
        run_op(4'd5, 8'h03, 8'h03, 1'b0, lat, bc);
        $display("SEQ after illegal: out=%h illegal=%b", out, illegal);
        total++; if ({out, illegal} !== {8'h01, 1'b0}) begin
            bad++; $display("FAIL illegal_clear got=%h/%b exp=01/0", out, illegal);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op = 4'd0; a = 8'h10; b = 8'h20; sc = 1'b0; start = 1'b1;
        @(negedge clk);
        total++; if ({done, out} !== {1'b1, 8'h30}) begin
            bad++; $display("FAIL b2b_first got=%b/%h exp=1/30", done, out);
        end
        // Start stays high in the Done cycle with a new request.
        op = 4'd3; a = 8'hFF; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        $display("back-to-back: second out=%h done=%b", out, done);
        total++; if ({done, out} !== {1'b1, 8'hF0}) begin
            bad++; $display("FAIL b2b_second got=%b/%h exp=1/F0", done, out);
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_busy_ignore();
        test_mask_reset();
        test_rotate_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
